// File: rtl/controle_cronometro_posse_pkg.sv
// Shared definitions for the shot-clock sequencer: state encoding, default load values, game-time width.
// No logic of its own; combinational helpers only.
package controle_cronometro_posse_pkg;

  localparam int TEMPO_W = 10;

  localparam logic [4:0] T_POSSE_DEF   = 5'd24;
  localparam logic [4:0] T_REBOTE_DEF  = 5'd14;
  localparam int         BUZ_TICKS_DEF = 3;

  typedef enum logic [2:0] {
    PARADO    = 3'd0,
    CARREGA   = 3'd1,
    RODANDO   = 3'd2,
    PAUSADO   = 3'd3,
    ESTOURO   = 3'd4,
    DESLIGADO = 3'd5
  } estado_t;

  // True when the remaining game time can hold a full shot-clock period of the given value.
  function automatic logic cabe_no_jogo(input logic [TEMPO_W-1:0] restante,
                                        input logic [4:0]         valor);
    return restante >= TEMPO_W'(valor);
  endfunction

endpackage

// File: rtl/estica_buzina.sv
// Stretches the one-cycle expiry trigger into a buzzer level lasting BUZ_TICKS tick_1hz pulses.
// Registered output, one cycle after trigger; clear wins over ticks, trigger wins over clear.
module estica_buzina #(
  parameter int BUZ_TICKS = 3
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic trigger,
  input  logic tick_1hz,
  input  logic clear,
  output logic buzina
);

  localparam int CW = ($clog2(BUZ_TICKS + 1) > 2) ? $clog2(BUZ_TICKS + 1) : 2;

  logic [CW-1:0] restam;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      restam <= '0;
      buzina <= 1'b0;
    end else if (trigger) begin
      // A tick coincident with the trigger is not part of the stretch.
      restam <= CW'(BUZ_TICKS);
      buzina <= (BUZ_TICKS != 0);
    end else if (clear) begin
      restam <= '0;
      buzina <= 1'b0;
    end else if (tick_1hz && (restam != '0)) begin
      restam <= restam - CW'(1);
      buzina <= (restam != CW'(1));
    end
  end

endmodule

// File: rtl/controle_cronometro_posse.sv
// Shot-clock sequencer: drives load value and run enable of the shot-clock counter from game events.
// All outputs registered, one cycle after the event; no backpressure, lower-priority events in a cycle are dropped.
module controle_cronometro_posse
  import controle_cronometro_posse_pkg::*;
#(
  parameter logic [4:0] T_POSSE   = T_POSSE_DEF,
  parameter logic [4:0] T_REBOTE  = T_REBOTE_DEF,
  parameter int         BUZ_TICKS = BUZ_TICKS_DEF
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               tick_1hz,
  input  logic               btn_posse,
  input  logic               btn_rebote,
  input  logic               btn_pausa,
  input  logic               jogo_rodando,
  input  logic [TEMPO_W-1:0] jogo_restante,
  input  logic [4:0]         contagem,
  input  logic               buzzer_in,
  output logic [4:0]         carga,
  output logic               corre,
  output logic               buzina,
  output logic               exibe,
  output logic [2:0]         estado
);

  estado_t    estado_q, estado_d;
  logic [4:0] alvo_q, alvo_d;
  logic       em_jogo;
  logic       buz_trigger, buz_clear;

  assign em_jogo = (estado_q == RODANDO) || (estado_q == PAUSADO);

  always_comb begin
    estado_d = estado_q;
    alvo_d   = alvo_q;
    if (btn_posse) begin
      alvo_d   = T_POSSE;
      estado_d = cabe_no_jogo(jogo_restante, T_POSSE) ? CARREGA : DESLIGADO;
    end else if (btn_rebote && em_jogo) begin
      // A rebound with plenty of shot clock left still consumes the cycle.
      if (contagem < T_REBOTE) begin
        alvo_d   = T_REBOTE;
        estado_d = cabe_no_jogo(jogo_restante, T_REBOTE) ? CARREGA : DESLIGADO;
      end
    end else if (btn_pausa && em_jogo) begin
      if (estado_q == RODANDO) begin
        estado_d = PAUSADO;
      end else if (jogo_rodando) begin
        estado_d = RODANDO;
      end
    end else begin
      unique case (estado_q)
        CARREGA: begin
          if (tick_1hz) begin
            estado_d = jogo_rodando ? RODANDO : PAUSADO;
          end
        end
        RODANDO: begin
          if (!jogo_rodando) begin
            estado_d = PAUSADO;
          end else if (buzzer_in || (contagem == 5'd0)) begin
            estado_d = ESTOURO;
          end else if (jogo_restante < TEMPO_W'(contagem)) begin
            estado_d = DESLIGADO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= PARADO;
      alvo_q   <= T_POSSE;
      carga    <= 5'd0;
      corre    <= 1'b0;
      exibe    <= 1'b1;
    end else begin
      estado_q <= estado_d;
      alvo_q   <= alvo_d;
      carga    <= (estado_d == CARREGA) ? alvo_d : 5'd0;
      corre    <= (estado_d == RODANDO);
      exibe    <= (estado_d != DESLIGADO);
    end
  end

  assign estado      = estado_q;
  assign buz_trigger = (estado_d == ESTOURO) && (estado_q != ESTOURO);
  assign buz_clear   = (estado_d != ESTOURO);

  estica_buzina #(
    .BUZ_TICKS (BUZ_TICKS)
  ) u_estica_buzina (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .trigger  (buz_trigger),
    .tick_1hz (tick_1hz),
    .clear    (buz_clear),
    .buzina   (buzina)
  );

endmodule

// File: tb/tb_controle_cronometro_posse.sv
// Directed plus randomized bench for the shot-clock sequencer against a behavioural model and a counter model.
module tb_controle_cronometro_posse;
  import controle_cronometro_posse_pkg::*;

  localparam int TP = 24;
  localparam int TR = 14;
  localparam int BT = 3;

  logic       clock_in      = 1'b0;
  logic       reset_n       = 1'b1;
  logic       tick_1hz      = 1'b0;
  logic       btn_posse     = 1'b0;
  logic       btn_rebote    = 1'b0;
  logic       btn_pausa     = 1'b0;
  logic       jogo_rodando  = 1'b0;
  logic [9:0] jogo_restante = 10'd0;
  logic [4:0] contagem      = 5'd0;
  logic       buzzer_in     = 1'b0;
  logic [4:0] carga;
  logic       corre;
  logic       buzina;
  logic       exibe;
  logic [2:0] estado;

  int tests = 0;
  int fails = 0;

  estado_t m_st;
  int      m_alvo;
  int      m_buz;
  int      cnt;
  int      buz_ticks;

  always #5 clock_in = ~clock_in;

  controle_cronometro_posse dut (
    .clock_in      (clock_in),
    .reset_n       (reset_n),
    .tick_1hz      (tick_1hz),
    .btn_posse     (btn_posse),
    .btn_rebote    (btn_rebote),
    .btn_pausa     (btn_pausa),
    .jogo_rodando  (jogo_rodando),
    .jogo_restante (jogo_restante),
    .contagem      (contagem),
    .buzzer_in     (buzzer_in),
    .carga         (carga),
    .corre         (corre),
    .buzina        (buzina),
    .exibe         (exibe),
    .estado        (estado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st   = PARADO;
    m_alvo = TP;
    m_buz  = 0;
  endtask

  // Reference behaviour: one clock of the sequencer, computed from the game rules.
  task automatic model_step();
    estado_t nx;
    int      na;
    bit      jogo;
    int      rest;
    nx   = m_st;
    na   = m_alvo;
    jogo = (m_st == RODANDO) || (m_st == PAUSADO);
    rest = int'(jogo_restante);
    if (btn_posse) begin
      na = TP;
      nx = (rest < TP) ? DESLIGADO : CARREGA;
    end else if (btn_rebote && jogo) begin
      if (cnt < TR) begin
        na = TR;
        nx = (rest < TR) ? DESLIGADO : CARREGA;
      end
    end else if (btn_pausa && jogo) begin
      if (m_st == RODANDO) nx = PAUSADO;
      else if (jogo_rodando) nx = RODANDO;
    end else if (m_st == CARREGA) begin
      if (tick_1hz) nx = jogo_rodando ? RODANDO : PAUSADO;
    end else if (m_st == RODANDO) begin
      if (!jogo_rodando) nx = PAUSADO;
      else if (buzzer_in || cnt == 0) nx = ESTOURO;
      else if (rest < cnt) nx = DESLIGADO;
    end
    if (nx == ESTOURO && m_st != ESTOURO) m_buz = BT;
    else if (nx != ESTOURO) m_buz = 0;
    else if (tick_1hz && m_buz > 0) m_buz--;
    m_st   = nx;
    m_alvo = na;
  endtask

  task automatic check_all();
    chk("estado", 32'(estado), 32'(m_st));
    chk("carga", 32'(carga), (m_st == CARREGA) ? m_alvo : 0);
    chk("corre", 32'(corre), (m_st == RODANDO) ? 1 : 0);
    chk("exibe", 32'(exibe), (m_st == DESLIGADO) ? 0 : 1);
    chk("buzina", 32'(buzina), (m_buz > 0) ? 1 : 0);
  endtask

  task automatic cycle(input bit p, input bit r, input bit pa, input bit t);
    int cnt_n;
    btn_posse  = p;
    btn_rebote = r;
    btn_pausa  = pa;
    tick_1hz   = t;
    model_step();
    // Shot-clock counter: load wins, otherwise count down on ticks while enabled.
    if (carga != 5'd0) cnt_n = int'(carga);
    else if (corre && t && cnt > 0) cnt_n = cnt - 1;
    else cnt_n = cnt;
    @(posedge clock_in);
    #1;
    cnt        = cnt_n;
    contagem   = 5'(cnt);
    btn_posse  = 1'b0;
    btn_rebote = 1'b0;
    btn_pausa  = 1'b0;
    tick_1hz   = 1'b0;
    check_all();
  endtask

  initial begin
    cnt           = 0;
    jogo_rodando  = 1'b1;
    jogo_restante = 10'd600;
    m_reset();
    #1 reset_n = 1'b0;
    #2;
    check_all();
    @(negedge clock_in);
    reset_n = 1'b1;
    @(posedge clock_in);
    #1;

    // Possession, full countdown, violation buzzer.
    cycle(1, 0, 0, 0);
    chk("carga_posse", 32'(carga), TP);
    repeat (3) cycle(0, 0, 0, 0);
    chk("carga_held", 32'(carga), TP);
    cycle(0, 0, 0, 1);
    chk("carga_after_tick", 32'(carga), 0);
    chk("corre_after_tick", 32'(corre), 1);
    buz_ticks = 0;
    for (int i = 0; i < 40; i++) begin
      if (buzina === 1'b1) buz_ticks++;
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
    end
    chk("buz_ticks", buz_ticks, BT);
    chk("estouro_hold", 32'(estado), 32'(ESTOURO));

    // Rebound with little time left reloads 14.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (15) cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    chk("carga_rebote", 32'(carga), TR);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("carga_rebote_end", 32'(carga), 0);

    // Rebound with plenty of time left is a no-op.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    chk("rebote_18_estado", 32'(estado), 32'(RODANDO));
    chk("rebote_18_carga", 32'(carga), 0);

    // Pause toggling and game clock stop.
    cycle(0, 0, 1, 0);
    chk("pausa_corre0", 32'(corre), 0);
    cycle(0, 0, 1, 0);
    chk("pausa_corre1", 32'(corre), 1);
    jogo_rodando = 1'b0;
    cycle(0, 0, 0, 0);
    chk("jogo_parado", 32'(estado), 32'(PAUSADO));
    cycle(0, 0, 1, 0);
    chk("pausa_sem_jogo", 32'(estado), 32'(PAUSADO));
    jogo_rodando = 1'b1;
    cycle(0, 0, 1, 0);

    // Not enough game time for a full possession.
    jogo_restante = 10'd20;
    cycle(1, 0, 0, 0);
    chk("deslig_exibe", 32'(exibe), 0);
    chk("deslig_carga", 32'(carga), 0);
    repeat (3) cycle(0, 0, 0, 1);
    jogo_restante = 10'd30;
    cycle(1, 0, 0, 0);
    chk("religa_estado", 32'(estado), 32'(CARREGA));
    chk("religa_carga", 32'(carga), TP);
    chk("religa_exibe", 32'(exibe), 1);
    cycle(0, 0, 0, 1);
    jogo_restante = 10'd600;

    // Simultaneous buttons: possession wins.
    cycle(1, 1, 1, 0);
    chk("prio_estado", 32'(estado), 32'(CARREGA));
    chk("prio_carga", 32'(carga), TP);

    // Asynchronous reset in the middle of a load window.
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("arst_carga", 32'(carga), 0);
    chk("arst_corre", 32'(corre), 0);
    chk("arst_estado", 32'(estado), 32'(PARADO));
    @(negedge clock_in);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) jogo_rodando = ~jogo_rodando;
      if ($urandom_range(0, 29) == 0)
        jogo_restante = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 40)) : 10'd600;
      buzzer_in = ($urandom_range(0, 49) == 0);
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0);
    end
    buzzer_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controle_cronometro_posse.md
# controle_cronometro_posse

Shot-clock sequencer for the basketball scoreboard. Drives the load value and run enable of the regressive shot-clock counter, reacts to possession, rebound/foul, pause and game-clock events, and stretches the violation buzzer. Sits between the button debouncers/game-clock block and the shot-clock counter.

## Interface
- T_POSSE, 24: load value on possession change (5-bit).
- T_REBOTE, 14: load value on offensive rebound/foul.
- BUZ_TICKS, 3: buzzer duration in 1 Hz ticks.
- clock_in  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse; counter advances/samples on this event.
- btn_posse  in  1  one-cycle pulse, possession change.
- btn_rebote  in  1  one-cycle pulse, offensive rebound/foul.
- btn_pausa  in  1  one-cycle pulse, toggle pause.
- jogo_rodando  in  1  level, game clock running.
- jogo_restante  in  10  game-clock seconds remaining.
- contagem  in  5  current shot-clock value from counter.
- buzzer_in  in  1  counter's expiry flag.
- carga  out  5  load value to counter; 0 = no load.
- corre  out  1  counter run enable (1 = count).
- buzina  out  1  stretched buzzer.
- exibe  out  1  shot-clock display enable.
- estado  out  3  current state, debug.

## Operation
- States: PARADO, CARREGA, RODANDO, PAUSADO, ESTOURO, DESLIGADO.
- Event priority, same cycle: btn_posse > btn_rebote > btn_pausa > jogo_rodando/jogo_restante/buzzer_in. Lower events that cycle are dropped.
- btn_posse, any state: target = T_POSSE. If jogo_restante < target, go to DESLIGADO. Otherwise, go to CARREGA.
- btn_rebote in RODANDO/PAUSADO:
  - If contagem < T_REBOTE: target = T_REBOTE, then the same DESLIGADO check, else CARREGA.
  - Otherwise no change.
  - Ignored in PARADO, ESTOURO, DESLIGADO.
- CARREGA:
  - carga = target, corre = 0.
  - corre must be 0, because the counter's decrement overrides its load.
  - On tick_1hz, go to RODANDO if jogo_rodando, else PAUSADO.
- RODANDO: corre = 1.
  - btn_pausa or jogo_rodando = 0 → PAUSADO.
  - buzzer_in = 1 or contagem = 0 → ESTOURO.
  - jogo_restante < contagem → DESLIGADO.
- PAUSADO: corre = 0. btn_pausa with jogo_rodando = 1 → RODANDO. btn_pausa with jogo_rodando = 0 is ignored.
- ESTOURO: corre = 0. buzina = 1 from entry for BUZ_TICKS tick_1hz pulses, then 0. Stays until btn_posse.
- DESLIGADO: exibe = 0, corre = 0, buzina = 0. Left only by btn_posse when jogo_restante ≥ T_POSSE.
- PARADO: post-reset idle, corre = 0. Left only by btn_posse.
- carga = 0 in every state except CARREGA.

## Timing
- Reset, asynchronous: state = PARADO, carga = 0, corre = 0, buzina = 0, exibe = 1, buzzer tick count = 0, target = T_POSSE.
- All outputs are registered.
- Event pulse at cycle n → new state and outputs visible at n+1.
- CARREGA holds carga until the first tick_1hz strictly after entry. carga returns to 0 and corre is updated the cycle after that tick.
- A tick coincident with entry does not count.
- btn_posse during CARREGA reloads target, stays in CARREGA and restarts the tick wait.
- Buzzer counter: 2 bits minimum, sized to BUZ_TICKS. Decrements on tick_1hz only, saturating at 0. btn_posse during stretch clears buzina next cycle.
- Reset asserted mid-CARREGA or mid-ESTOURO: immediate return to reset values. The counter keeps its value.
- Comparisons are unsigned. contagem is zero-extended to 10 bits before comparing with jogo_restante.

## Structure
- Shared package holds:
  - state encoding (3-bit, PARADO = 0);
  - T_POSSE / T_REBOTE defaults (5'd24 / 5'd14);
  - the 10-bit game-time width constant.
- One sub-module: estica_buzina (trigger, tick_1hz, clear → buzina, with BUZ_TICKS parameter).

## Test plan
- Reset, then btn_posse with jogo_restante = 600:
  - carga = 24 until the next tick, then carga = 0.
  - corre = 1 with jogo_rodando = 1.
  - contagem (model) decrements 24 → 0 → ESTOURO, buzina high for exactly 3 ticks.
- RODANDO, contagem = 9, btn_rebote → carga = 14 for one tick window. Repeat with contagem = 18 → no load, state stays RODANDO.
- btn_pausa in RODANDO → corre = 0 next cycle. btn_pausa again → corre = 1. Drop jogo_rodando in RODANDO → PAUSADO.
- jogo_restante = 20, btn_posse → DESLIGADO, exibe = 0, carga stays 0. Later btn_posse with jogo_restante = 30 → CARREGA with 24, exibe = 1.
- Same cycle btn_posse + btn_rebote + btn_pausa while RODANDO → CARREGA with 24. Pause is dropped.
- reset_n low mid-CARREGA (carga = 24) → carga = 0, corre = 0, state PARADO asynchronously, before the next clock edge.
